// File: rtl/jt89_ctrl.sv
// jt89_ctrl: bus-side register controller for the JT89 PSG.
// Decodes SN76489-style latch/data byte writes into tone periods,
// attenuations and noise control for the sound generators.
// Optional macro JT89_READY_EN compiles in a READY pacing FSM that
// holds off the CPU for 32 clk_en pulses after every accepted write.
module jt89_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic [7:0] din,
  input  logic       cs_n,
  input  logic       wr_n,
  output logic       ready,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] noise_ctl,
  output logic       noise_rst
);

  // Latched target of subsequent data bytes: channel and register type
  typedef struct packed {
    logic [1:0] ch;
    logic       typ;   // 1 = volume, 0 = tone/noise
  } latch_t;

  logic       stb, stb_l, accept, is_latch;
  latch_t     latch_q, cur;
  logic [2:0][9:0] tone_q;
  logic [3:0][3:0] vol_q;
  logic       wr_vol, wr_tone_lo, wr_tone_hi, wr_noise;

  assign stb      = !cs_n && !wr_n;
  // Edge-detected so a long strobe produces one acceptance only
  assign accept   = stb && !stb_l && ready;
  assign is_latch = din[7];
  // Latch bytes carry their own target, data bytes reuse the stored one
  assign cur      = is_latch ? latch_t'({din[6:5], din[4]}) : latch_q;

  assign wr_vol     = accept && cur.typ;
  assign wr_tone_lo = accept &&  is_latch && !cur.typ && (cur.ch != 2'd3);
  assign wr_tone_hi = accept && !is_latch && !cur.typ && (cur.ch != 2'd3);
  assign wr_noise   = accept && !cur.typ && (cur.ch == 2'd3);

  assign tone0 = tone_q[0];
  assign tone1 = tone_q[1];
  assign tone2 = tone_q[2];
  assign vol0  = vol_q[0];
  assign vol1  = vol_q[1];
  assign vol2  = vol_q[2];
  assign vol3  = vol_q[3];

  // Strobe history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stb_l <= 1'b0;
    else        stb_l <= stb;
  end

  // Register file: latch, tone periods, attenuations, noise control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q   <= '0;
      tone_q    <= '0;
      vol_q     <= {4{4'hF}};
      noise_ctl <= 3'd0;
      noise_rst <= 1'b0;
    end else begin
      noise_rst <= wr_noise;
      if (accept && is_latch) latch_q <= cur;
      if (wr_noise) noise_ctl <= din[2:0];
      if (wr_vol) vol_q[cur.ch] <= din[3:0];
      if (wr_tone_lo) begin
        case (cur.ch)
          2'd0:    tone_q[0][3:0] <= din[3:0];
          2'd1:    tone_q[1][3:0] <= din[3:0];
          default: tone_q[2][3:0] <= din[3:0];
        endcase
      end
      if (wr_tone_hi) begin
        case (cur.ch)
          2'd0:    tone_q[0][9:4] <= din[5:0];
          2'd1:    tone_q[1][9:4] <= din[5:0];
          default: tone_q[2][9:4] <= din[5:0];
        endcase
      end
    end
  end

`ifdef JT89_READY_EN
  typedef enum logic { IDLE, BUSY } st_t;
  st_t        st;
  logic [4:0] cnt;

  // READY pacing: busy for 32 clk_en pulses after each accepted write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      ready <= 1'b1;
      cnt   <= 5'd0;
    end else begin
      case (st)
        IDLE: if (accept) begin
          st    <= BUSY;
          ready <= 1'b0;
          cnt   <= 5'd31;
        end
        default: if (clk_en) begin
          if (cnt == 5'd0) begin
            st    <= IDLE;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
      endcase
    end
  end
`else
  logic unused_clk_en;
  assign unused_clk_en = clk_en;
  assign ready = 1'b1;
`endif

endmodule

// File: tb/tb_jt89_ctrl.sv
// Self-checking bench for jt89_ctrl: scoreboard of expected register
// snapshots pushed at each write and popped at the accepting edge.
// Build with +define+JT89_READY_EN to also exercise READY pacing.
module tb_jt89_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1;
  logic       cs_n = 1'b1, wr_n = 1'b1;
  logic [7:0] din = 8'h00;
  logic       ready, noise_rst;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] noise_ctl;

  jt89_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .din(din), .cs_n(cs_n),
    .wr_n(wr_n), .ready(ready), .tone0(tone0), .tone1(tone1), .tone2(tone2),
    .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3),
    .noise_ctl(noise_ctl), .noise_rst(noise_rst)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  typedef struct packed {
    logic [9:0] t0, t1, t2;
    logic [3:0] v0, v1, v2, v3;
    logic [2:0] nc;
  } snap_t;
  snap_t exp_q[$];

  // Reference model state
  logic [9:0] m_tone[3];
  logic [3:0] m_vol[4];
  logic [2:0] m_nc;
  logic [1:0] m_ch;
  logic       m_typ;

  logic       en_mode = 1'b0;
  logic [1:0] div = 2'd0;

  // clk_en every 4th clk in pacing mode, else always on
  always @(posedge clk) begin
    #1;
    div    = div + 2'd1;
    clk_en = !en_mode || (div == 2'd0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_tone[i] = 10'd0;
    for (int i = 0; i < 4; i++) m_vol[i] = 4'hF;
    m_nc = 3'd0; m_ch = 2'd0; m_typ = 1'b0;
  endfunction

  // Applies one accepted byte; returns 1 when a noise_rst pulse is due
  function automatic logic model_apply(input logic [7:0] d);
    logic p;
    p = 1'b0;
    if (d[7]) begin
      m_ch = d[6:5]; m_typ = d[4];
      if (m_typ) m_vol[m_ch] = d[3:0];
      else if (m_ch != 2'd3) m_tone[m_ch][3:0] = d[3:0];
      else begin m_nc = d[2:0]; p = 1'b1; end
    end else begin
      if (m_typ) m_vol[m_ch] = d[3:0];
      else if (m_ch != 2'd3) m_tone[m_ch][9:4] = d[5:0];
      else begin m_nc = d[2:0]; p = 1'b1; end
    end
    return p;
  endfunction

  function automatic snap_t model_snap();
    return '{m_tone[0], m_tone[1], m_tone[2], m_vol[0], m_vol[1], m_vol[2], m_vol[3], m_nc};
  endfunction

  function automatic snap_t dut_snap();
    return '{tone0, tone1, tone2, vol0, vol1, vol2, vol3, noise_ctl};
  endfunction

  task automatic cmp_snap(input string tag);
    snap_t e, g;
    if (exp_q.size() == 0) begin
      chk({tag, "_q"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    g = dut_snap();
    chk({tag, "_t0"}, g.t0, e.t0);
    chk({tag, "_t1"}, g.t1, e.t1);
    chk({tag, "_t2"}, g.t2, e.t2);
    chk({tag, "_v0"}, g.v0, e.v0);
    chk({tag, "_v1"}, g.v1, e.v1);
    chk({tag, "_v2"}, g.v2, e.v2);
    chk({tag, "_v3"}, g.v3, e.v3);
    chk({tag, "_nc"}, g.nc, e.nc);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rdy_wait", ready, 1);
  endtask

  // One write: strobe for a single edge, then one idle edge
  task automatic wr(input logic [7:0] d);
    logic p;
    wait_ready();
    din = d; cs_n = 1'b0; wr_n = 1'b0;
    p = model_apply(d);
    exp_q.push_back(model_snap());
    @(posedge clk); #1;
    cmp_snap($sformatf("wr%02h", d));
    chk($sformatf("nrst%02h", d), noise_rst, p);
    cs_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("nrst_off%02h", d), noise_rst, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int pulses, iter;
    model_reset();

    // Reset values
    #12;
    chk("rst_tones", {tone0, tone1, tone2}, 30'd0);
    chk("rst_vols", {vol0, vol1, vol2, vol3}, 16'hFFFF);
    chk("rst_nc", noise_ctl, 0);
    chk("rst_ready", ready, 1);
    chk("rst_nrst", noise_rst, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Channel 0 tone: low nibble then high six bits
    wr(8'h8E);
    wr(8'h0F);
    chk("tone0_0FE", tone0, 10'h0FE);
    chk("tone1_keep", tone1, 0);
    chk("tone2_keep", tone2, 0);

    // Channel 1 volume via latch then data byte
    wr(8'hB5);
    chk("vol1_5", vol1, 4'h5);
    wr(8'h07);
    chk("vol1_7", vol1, 4'h7);

    // Noise control with pulses
    wr(8'hE6);
    chk("nc_6", noise_ctl, 3'd6);
    wr(8'h03);
    chk("nc_3", noise_ctl, 3'd3);

    // Mixed random traffic
    for (int i = 0; i < 24; i++) wr(8'($urandom_range(0, 255)));

`ifdef JT89_READY_EN
    // READY pacing with clk_en every 4th clk
    wait_ready();
    en_mode = 1'b1;
    din = 8'h9A; cs_n = 1'b0; wr_n = 1'b0;
    void'(model_apply(8'h9A));
    exp_q.push_back(model_snap());
    @(posedge clk); #1;
    cmp_snap("rdy9A");
    chk("rdy_low", ready, 0);
    cs_n = 1'b1; wr_n = 1'b1;
    pulses = 0; iter = 0;
    while (iter < 600) begin
      @(negedge clk);
      if (ready) break;
      if (clk_en) pulses++;
      iter++;
      if (iter == 8)  begin din = 8'h90; cs_n = 1'b0; wr_n = 1'b0; end
      if (iter == 10) begin cs_n = 1'b1; wr_n = 1'b1; end
      if (iter == 14) begin din = 8'h9F; cs_n = 1'b0; wr_n = 1'b0; end
    end
    chk("busy_pulses", pulses, 32);
    // Strobe still held across READY return must not be accepted
    repeat (6) @(posedge clk);
    #1;
    chk("held_ready", ready, 1);
    exp_q.push_back(model_snap());
    cmp_snap("held");
    chk("vol0_A", vol0, 4'hA);
    cs_n = 1'b1; wr_n = 1'b1;
    en_mode = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
`endif

    // Asynchronous reset after tone writes (mid-BUSY when pacing)
    wr(8'h85);
    wr(8'h2A);
    chk("tone0_2A5", tone0, 10'h2A5);
`ifdef JT89_READY_EN
    chk("busy_pre", ready, 0);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", ready, 1);
    chk("arst_tones", {tone0, tone1, tone2}, 30'd0);
    chk("arst_vols", {vol0, vol1, vol2, vol3}, 16'hFFFF);
    chk("arst_nc", noise_ctl, 0);
    chk("arst_nrst", noise_rst, 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    wr(8'hC3);
    chk("tone2_3", tone2, 10'h003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
